// File: rtl/disp4_bcd_scan_pkg.sv
// rtl/disp4_bcd_scan_pkg.sv - shared constants and state encoding for the 4-digit BCD display feeder
package disp4_bcd_scan_pkg;

   localparam int          DIGITS         = 4;
   localparam int          BIN_W          = 14;
   localparam logic [13:0] BCD_MAX        = 14'd9999;
   localparam logic [3:0]  BCD_ERR_NIBBLE = 4'hE;
   localparam logic [3:0]  AN_RESET       = 4'b1110;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/disp4_bcd_scan_bin2bcd_seq.sv
// rtl/disp4_bcd_scan_bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
   import disp4_bcd_scan_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   logic [BIN_W-1:0]    sh_bin;
   logic [4*DIGITS-1:0] sh_bcd;
   logic [4*DIGITS-1:0] adj;
   logic [3:0]          cnt;
   logic                running;

   always_comb begin
      adj = sh_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (sh_bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
      end
   end

   // done marks the cycle whose closing edge performs the final iteration
   assign done = running && (cnt == 4'(BIN_W - 1));
   assign bcd  = sh_bcd;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_bin  <= '0;
         sh_bcd  <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         sh_bin  <= bin;
         sh_bcd  <= '0;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
         cnt              <= cnt + 4'd1;
         if (done)
            running <= 1'b0;
      end
   end

endmodule

// File: rtl/disp4_bcd_scan.sv
// rtl/disp4_bcd_scan.sv - latches a binary value, converts it to BCD and scans 4 digits onto one bus
module disp4_bcd_scan
   import disp4_bcd_scan_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  bin_in,
   input  logic              load,
   output logic              busy,
   output logic              ovf,
   output logic [3:0]        bcd_out,
   output logic [3:0]        an
);

   localparam int             PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);

   state_t              state;
   logic [4*DIGITS-1:0] disp;
   logic [4*DIGITS-1:0] disp_d;
   logic [4*DIGITS-1:0] eng_bcd;
   logic                eng_done;
   logic                eng_start;
   logic                over;
   logic [PW-1:0]       presc;
   logic [1:0]          idx;
   logic [1:0]          idx_d;
   logic                wrap;

   assign over      = (bin_in > BCD_MAX);
   assign eng_start = (state == IDLE) && load && !over;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (eng_start),
      .bin   (bin_in),
      .done  (eng_done),
      .bcd   (eng_bcd)
   );

   // next display value is shared with the scan registers so new digits appear on the same edge
   always_comb begin
      disp_d = disp;
      if ((state == IDLE) && load && over)
         disp_d = {DIGITS{BCD_ERR_NIBBLE}};
      else if (state == COMMIT)
         disp_d = eng_bcd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         disp  <= '0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         disp <= disp_d;
         case (state)
            IDLE: begin
               if (load) begin
                  if (over) begin
                     ovf <= 1'b1;
                  end else begin
                     ovf   <= 1'b0;
                     busy  <= 1'b1;
                     state <= CONV;
                  end
               end
            end
            CONV: begin
               if (eng_done)
                  state <= COMMIT;
            end
            COMMIT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign wrap = (presc == PMAX);

   always_comb begin
      idx_d = idx;
      if (wrap)
         idx_d = idx + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= '0;
         idx     <= 2'd0;
         an      <= AN_RESET;
         bcd_out <= 4'h0;
      end else begin
         presc   <= wrap ? '0 : presc + 1'b1;
         idx     <= idx_d;
         an      <= ~(4'b0001 << idx_d);
         bcd_out <= disp_d[{idx_d, 2'b00} +: 4];
      end
   end

endmodule

// File: tb/tb_disp4_bcd_scan.sv
// tb/tb_disp4_bcd_scan.sv - directed self-checking bench for disp4_bcd_scan with a fast scan rate
module tb_disp4_bcd_scan;

   logic        clk;
   logic        rst;
   logic [13:0] bin_in;
   logic        load;
   logic        busy;
   logic        ovf;
   logic [3:0]  bcd_out;
   logic [3:0]  an;

   int total = 0;
   int bad   = 0;

   disp4_bcd_scan #(.REFRESH_DIV(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .bin_in  (bin_in),
      .load    (load),
      .busy    (busy),
      .ovf     (ovf),
      .bcd_out (bcd_out),
      .an      (an)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic pulse_load(input logic [13:0] v);
      bin_in = v;
      load   = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic wait_busy(input string tag, input logic [15:0] old);
      int n;
      int hold_bad;
      int k;
      n = 0;
      hold_bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         k = an_idx(an);
         if (k < 0 || bcd_out !== old[4*k +: 4]) hold_bad++;
      end
      check({tag, "_busy_len"}, n, 15);
      check({tag, "_hold"}, hold_bad, 0);
   endtask

   task automatic read_disp(input string tag, input logic [15:0] exp);
      logic [15:0] v;
      logic [3:0]  seen;
      int          k;
      int          odd;
      v = '0;
      seen = '0;
      odd = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         k = an_idx(an);
         if (k < 0) begin
            odd++;
         end else begin
            v[4*k +: 4] = bcd_out;
            seen[k] = 1'b1;
         end
      end
      check({tag, "_an_onecold"}, odd, 0);
      check({tag, "_digits_seen"}, seen, 4'hF);
      check({tag, "_display"}, v, exp);
   endtask

   task automatic convert(input string tag, input logic [13:0] v, input logic [15:0] old,
                          input logic [15:0] exp);
      pulse_load(v);
      wait_busy(tag, old);
      read_disp(tag, exp);
      check({tag, "_ovf"}, ovf, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      load   = 1'b0;
      bin_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      for (int j = 0; j < 20; j++) begin
         logic [3:0] exp_an;
         case ((j / 4) % 4)
            0: exp_an = 4'b1110;
            1: exp_an = 4'b1101;
            2: exp_an = 4'b1011;
            default: exp_an = 4'b0111;
         endcase
         check($sformatf("rst_an_%0d", j), an, exp_an);
         check($sformatf("rst_bcd_%0d", j), bcd_out, 0);
         @(negedge clk);
      end

      convert("c1234", 14'd1234, 16'h0000, 16'h1234);
      convert("c9999", 14'd9999, 16'h1234, 16'h9999);
      convert("c0", 14'd0, 16'h9999, 16'h0000);

      pulse_load(14'd10000);
      @(negedge clk);
      check("ovf_busy", busy, 0);
      check("ovf_flag", ovf, 1);
      check("ovf_nibble", bcd_out, 4'hE);
      read_disp("ovf", 16'hEEEE);
      check("ovf_busy_after", busy, 0);
      check("ovf_flag_after", ovf, 1);

      convert("c5", 14'd5, 16'hEEEE, 16'h0005);

      pulse_load(14'd1234);
      for (int c = 1; c <= 15; c++) begin
         check($sformatf("lwb_busy_%0d", c), busy, 1);
         if (c == 3 || c == 15) begin
            bin_in = 14'd777;
            load   = 1'b1;
         end
         @(posedge clk);
         #1 load = 1'b0;
         @(negedge clk);
      end
      check("lwb_idle", busy, 0);
      begin
         int k;
         k = an_idx(an);
         check("lwb_an", (k < 0) ? 1 : 0, 0);
         if (k >= 0) begin
            logic [15:0] r;
            r = 16'h1234;
            check("lwb_result", bcd_out, r[4*k +: 4]);
         end
      end
      pulse_load(14'd777);
      wait_busy("l777", 16'h1234);
      read_disp("l777", 16'h0777);

      pulse_load(14'd4321);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_an", an, 4'b1110);
      check("mid_rst_bcd", bcd_out, 0);
      begin
         int late;
         late = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) late++;
         end
         check("mid_rst_no_busy", late, 0);
      end
      read_disp("mid_rst", 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
